paced_queue: RTL

RAM-backed FIFO that sits directly downstream of the 50 MHz→2 Hz clock divider and consumes its clk_div output.
- Producers push words at full clk rate through a valid/ready handshake.
- Exactly one word is popped per rising edge of clk_div, giving a human-visible stream for LEDs or a 7-segment display.
- Single clock domain: clk_div is sampled as data, never used as a clock.

---
 rtl/paced_pkg.sv | 6 +
 rtl/pulse_sync_edge.sv | 42 ++++
 rtl/paced_queue.sv | 83 ++++++++
 3 files changed

// File: rtl/paced_pkg.sv
// Shared defaults for the paced queue and its pacing-edge detector.
package paced_pkg;
  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_DEPTH  = 16;
  localparam int SYNC_STAGES    = 2;
endpackage

// File: rtl/pulse_sync_edge.sv
// Synchroniser plus rising-edge detector for a slow asynchronous level.
// The edge is only reported after a genuine low has been observed since reset,
// so a level that is already high when reset releases never produces a step.
module pulse_sync_edge
  import paced_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic step
);

  logic [STAGES-1:0] sync;
  logic [STAGES-1:0] fill;
  logic              hist;
  logic              low_seen;
  logic              s_last;

  assign s_last = sync[STAGES-1];
  assign step   = s_last & ~hist & low_seen;

  // Synchroniser chain, history flop and arming of the edge detector.
  // The reset-cleared zeros in the chain are not real samples of sig_in, so
  // fill tracks when the last stage holds a genuine sample before a low
  // there is allowed to arm low_seen.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync     <= '0;
      fill     <= '0;
      hist     <= 1'b0;
      low_seen <= 1'b0;
    end else begin
      sync     <= {sync[STAGES-2:0], sig_in};
      fill     <= {fill[STAGES-2:0], 1'b1};
      hist     <= s_last;
      low_seen <= low_seen | (fill[STAGES-1] & ~s_last);
    end
  end

endmodule

// File: rtl/paced_queue.sv
// RAM-backed FIFO filled at full clock rate and drained one word per rising
// edge of the slow pacing signal clk_div (sampled as data, never a clock).
module paced_queue
  import paced_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_div,
  input  logic              pace_en,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              step_miss
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              step;
  logic              push;
  logic              pop;

  pulse_sync_edge #(.STAGES(SYNC_STAGES)) u_pace (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_in (clk_div),
    .step   (step)
  );

  // Flags come from the registered count only, so a same-cycle pop never
  // opens wr_ready and a same-cycle push never enables a pop.
  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign wr_ready = ~full;
  assign push     = wr_valid & ~full;
  assign pop      = step & pace_en & ~empty;

  // Storage array; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers, occupancy and the paced output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      step_miss <= 1'b0;
    end else begin
      out_valid <= pop;
      step_miss <= step & pace_en & empty;
      if (push) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + ADDR_W'(1);
        out_data <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
